clock_field_alu: RTL
====================

// Module: clock_field_alu
// PURPOSE
//  Executing end of the registered 2-bit ALU op code from the control-signal stage.
//  Holds one time/date field (sec, min, hour, day, month, year-lo) and applies hold/inc/dec/load per op.
//  Wraps within [MIN_VAL, limit] and emits one-cycle carry/borrow pulses that chain into the next field.
//  One instance per field; the date field takes its limit at run time (days-in-month).
// PARAMETERS
//  WIDTH    6   field value width in bits, 1..7; values up to 99
//  MIN_VAL  0   lowest legal value: 0 for time fields, 1 for day and month
//  MAX_VAL  59  static upper bound, used when USE_LIM=0
//  USE_LIM  0   1: upper bound comes from the lim port instead of MAX_VAL
// PORTS
//  clk       in   1      system clock, rising edge
//  rst_n     in   1      asynchronous active-low reset
//  en        in   1      op qualifier; op is ignored when 0
//  op        in   2      ALU op code: 00 hold, 01 inc, 10 dec, 11 load
//  load_val  in   WIDTH  value applied on load
//  lim       in   WIDTH  run-time upper bound, used only when USE_LIM=1
//  value     out  WIDTH  current field value, registered
//  carry     out  1      one-cycle pulse on inc wrap
//  borrow    out  1      one-cycle pulse on dec wrap
//  err       out  1      one-cycle pulse when a load is out of range
// BEHAVIOUR
//  - Reset (async assert, sync release): value=MIN_VAL, carry=0, borrow=0, err=0.
//  - lim_eff = USE_LIM ? lim : MAX_VAL. Legal range is MIN_VAL..lim_eff.
//  - All outputs are registered, with 1-cycle latency: an op sampled at edge N is visible after edge N.
//  - carry/borrow/err are 0 in every cycle without their event; they never stay high 2 cycles unless re-triggered.
//  - en=0 or op=00 (hold): value unchanged, except the clamp rule below.
//  - op=01 inc:
//      value>=lim_eff -> value=MIN_VAL, carry=1
//      otherwise -> value+1
//  - op=10 dec:
//      value<=MIN_VAL -> value=lim_eff, borrow=1
//      otherwise -> value-1
//  - op=11 load:
//      MIN_VAL<=load_val<=lim_eff -> value=load_val
//      otherwise -> value=MIN_VAL, err=1
//      no carry or borrow in either case
//  - Clamp: if value>lim_eff (lim dropped, e.g. day 31 -> Feb limit 28) and no inc/load is active -> value=lim_eff.
//      dec takes the clamped value minus 1.
//      inc treats value>lim_eff as a wrap.
//  - Arithmetic is WIDTH-bit unsigned; comparisons are unsigned; no intermediate overflow for legal params.
//  - lim<MIN_VAL is illegal config; the result is don't-care, but it must not lock up. The next legal lim recovers the field.
//  - Reset mid-operation: the pending op is discarded and any pulse in flight is cleared immediately.
//  - No internal state beyond value and the three pulse flops.
// CONFIGURATION
//  - FIELD_BCD_OUT_EN defined: adds output port bcd_out[7:0] = {tens, units} of value.
//      registered, updated on the same edge as value
//      reset to the BCD of MIN_VAL
//  - FIELD_BCD_OUT_EN undefined: the bcd_out port and its logic are absent; all other behaviour is identical.
// TESTING
//  1. Reset: rst_n=0 mid-inc with MIN_VAL=1 -> value=1 and carry/borrow/err=0 immediately, async.
//  2. Seconds wrap: value=59, en=1, op=01 -> next cycle value=0, carry=1 for exactly 1 cycle.
//     Then op=00 -> value=0, carry=0.
//  3. Dec wrap: MIN_VAL=1, MAX_VAL=12, value=1, op=10 -> value=12, borrow=1 for 1 cycle.
//  4. Load:
//     load_val=45 with bound 59 -> value=45, err=0.
//     load_val=60 -> value=0, err=1 for 1 cycle.
//  5. Run-time limit: USE_LIM=1, value=31, lim 31->28 with op=00 -> value=28 next cycle.
//     Then inc -> value=1, carry=1.
//  6. en gating + BCD: en=0, op=01 for 5 cycles -> value constant.
//     With FIELD_BCD_OUT_EN, value=47 -> bcd_out=8'h47.

Source files
------------

// File: rtl/clock_field_alu.sv
// One time/date field: hold/inc/dec/load with wrap, carry/borrow/err pulses and clamp to a run-time limit.
// Optional FIELD_BCD_OUT_EN adds a registered packed-BCD copy of the value on bcd_out.
module clock_field_alu #(
  parameter int WIDTH   = 6,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 59,
  parameter int USE_LIM = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] lim,
  output logic [WIDTH-1:0] value,
  output logic             carry,
  output logic             borrow,
  output logic             err
`ifdef FIELD_BCD_OUT_EN
  ,
  output logic [7:0]       bcd_out
`endif
);

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  logic [WIDTH-1:0] r_value;
  logic             r_carry;
  logic             r_borrow;
  logic             r_err;

  logic [WIDTH-1:0] w_lim_eff;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_next;
  logic             w_carry;
  logic             w_borrow;
  logic             w_err;
  logic             w_ld_low;
  op_e              w_op;

  assign w_lim_eff = (USE_LIM != 0) ? lim : MAX_V;
  assign w_op      = en ? op_e'(op) : OP_HOLD;

  // A value left above a freshly lowered limit is pulled down to it first.
  assign w_base = (r_value > w_lim_eff) ? w_lim_eff : r_value;

  // With MIN_VAL of zero no load can be below range; keep that comparison out of the logic.
  generate
    if (MIN_VAL == 0) begin : g_min_zero
      assign w_ld_low = 1'b0;
    end else begin : g_min_pos
      assign w_ld_low = (load_val < MIN_V);
    end
  endgenerate

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_next   = w_base;
    w_carry  = 1'b0;
    w_borrow = 1'b0;
    w_err    = 1'b0;
    case (w_op)
      OP_INC: begin
        if (r_value >= w_lim_eff) begin
          w_next  = MIN_V;
          w_carry = 1'b1;
        end else begin
          w_next = r_value + ONE_V;
        end
      end
      OP_DEC: begin
        if (w_base <= MIN_V) begin
          w_next   = w_lim_eff;
          w_borrow = 1'b1;
        end else begin
          w_next = w_base - ONE_V;
        end
      end
      OP_LOAD: begin
        if (!w_ld_low && (load_val <= w_lim_eff)) begin
          w_next = load_val;
        end else begin
          w_next = MIN_V;
          w_err  = 1'b1;
        end
      end
      default: w_next = w_base;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value  <= MIN_V;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      r_value  <= w_next;
      r_carry  <= w_carry;
      r_borrow <= w_borrow;
      r_err    <= w_err;
    end
  end

  assign value  = r_value;
  assign carry  = r_carry;
  assign borrow = r_borrow;
  assign err    = r_err;

`ifdef FIELD_BCD_OUT_EN
  localparam logic [7:0] BCD_MIN = 8'(((MIN_VAL / 10) * 16) + (MIN_VAL % 10));

  logic [7:0] r_bcd;
  logic [7:0] w_next_ext;
  logic [7:0] w_tens;
  logic [7:0] w_units;

  // Converted from the next value so the BCD copy lands on the same edge as value.
  assign w_next_ext = 8'(w_next);
  assign w_tens     = w_next_ext / 8'd10;
  assign w_units    = w_next_ext % 8'd10;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd <= BCD_MIN;
    end else begin
      r_bcd <= {w_tens[3:0], w_units[3:0]};
    end
  end

  assign bcd_out = r_bcd;
`endif

endmodule
